// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM.
//   - state_t   : controller state encoding
//   - OP_* / FN_*: recognised opcode and funct fields of the core ISA subset
//   - ALU_*     : alu_op codes driven to the ALU control
//   - SRCB_*    : alu_src_b mux select codes
//   - CAUSE_*   : trap_cause codes
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC_R,
      EXEC_I,
      MEM_RD,
      MEM_WR,
      WB_R,
      WB_I,
      WB_MEM,
      BRANCH,
      TRAP
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;

   // ALU B-operand select codes
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States that hold a request on the shared memory port
   function automatic logic is_mem_state(input state_t s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer for the multi-cycle controller.
// Counts consecutive cycles spent in a memory state without mem_ready and
// flags the cycle on which the count sits at the timeout limit.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force the count back to zero (takes priority over count_en)
//   count_en  : advance the count by one this cycle
//   expired   : count equals MAX_WAIT-1; a further unready cycle must trap
module mem_wait_timer #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT - 1);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wait_cnt <= '0;
      end else if (count_en) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   assign expired = (wait_cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared single-ALU / single-memory datapath.
// Sequences add, slt, lw, sw, addi and beq; raises a sticky trap on an
// illegal opcode/funct or on a memory request that stays unready too long.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   run             : keep issuing instructions (sampled at retire and in IDLE)
//   opcode, funct   : IR[31:26], IR[5:0]
//   zero            : ALU zero flag (beq decision)
//   mem_ready       : memory completes the current access this cycle
//   pc_write .. alu_op : per-cycle datapath strobes
//   inst_done       : pulse on the final cycle of every retired instruction
//   instr_count     : retired-instruction count, wraps
//   trap, trap_cause: sticky trap flag and its cause
module multicycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_source,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             inst_done,
   output logic [CNT_W-1:0] instr_count,
   output logic             trap,
   output logic [1:0]       trap_cause
);

   state_t     state;
   state_t     state_next;
   logic       retire;
   logic       trap_set;
   logic [1:0] cause_next;
   logic       mem_wait;
   logic       wait_expired;

   // The timer is cleared every cycle that is not an unready memory cycle.
   // Memory states are only left on mem_ready (or a trap), so this is the
   // same as clearing on entry to FETCH/MEM_RD/MEM_WR.
   assign mem_wait = is_mem_state(state) && !mem_ready;

   mem_wait_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (!mem_wait),
      .count_en (mem_wait),
      .expired  (wait_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_count <= '0;
         trap        <= 1'b0;
         trap_cause  <= CAUSE_NONE;
      end else begin
         if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
         end
         if (trap_set) begin
            trap       <= 1'b1;
            trap_cause <= cause_next;
         end
      end
   end

   always_comb begin
      state_next = state;
      retire     = 1'b0;
      trap_set   = 1'b0;
      cause_next = CAUSE_NONE;
      pc_write   = 1'b0;
      pc_source  = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      alu_op     = ALU_ADD;

      case (state)
         IDLE: begin
            if (run) begin
               state_next = FETCH;
            end
         end

         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) begin
               state_next = DECODE;
            end else if (wait_expired) begin
               state_next = TRAP;
               trap_set   = 1'b1;
               cause_next = CAUSE_TIMEOUT;
            end
         end

         DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            case (opcode)
               OP_RTYPE: begin
                  if (funct == FN_ADD || funct == FN_SLT) begin
                     state_next = EXEC_R;
                  end else begin
                     state_next = TRAP;
                     trap_set   = 1'b1;
                     cause_next = CAUSE_ILLEGAL;
                  end
               end
               OP_LW, OP_SW, OP_ADDI: state_next = EXEC_I;
               OP_BEQ:                state_next = BRANCH;
               default: begin
                  state_next = TRAP;
                  trap_set   = 1'b1;
                  cause_next = CAUSE_ILLEGAL;
               end
            endcase
         end

         EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_RT;
            alu_op     = (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
            state_next = WB_R;
         end

         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_LW:   state_next = MEM_RD;
               OP_SW:   state_next = MEM_WR;
               OP_ADDI: state_next = WB_I;
               default: begin
                  // IR changed underneath us; treat as illegal rather than guess
                  state_next = TRAP;
                  trap_set   = 1'b1;
                  cause_next = CAUSE_ILLEGAL;
               end
            endcase
         end

         MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               state_next = WB_MEM;
            end else if (wait_expired) begin
               state_next = TRAP;
               trap_set   = 1'b1;
               cause_next = CAUSE_TIMEOUT;
            end
         end

         MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               retire = 1'b1;
            end else if (wait_expired) begin
               state_next = TRAP;
               trap_set   = 1'b1;
               cause_next = CAUSE_TIMEOUT;
            end
         end

         WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
         end

         WB_I: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end

         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end

         BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RT;
            alu_op    = ALU_SUB;
            pc_source = 1'b1;
            pc_write  = zero;
            retire    = 1'b1;
         end

         TRAP: begin
            state_next = TRAP;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // run is only looked at on the retiring cycle, so a mid-instruction
      // drop never aborts the instruction in flight
      if (retire) begin
         state_next = run ? FETCH : IDLE;
      end
   end

   assign inst_done = retire;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared single-ALU/single-memory datapath for the core ISA subset: add, slt, lw, sw, addi, beq.
- Sits beside the IR, PC, register file, ALU and unified memory port.
- Consumes opcode/funct from the IR, the ALU zero flag and the memory ready handshake.
- Produces per-cycle datapath strobes, trap status and a retired-instruction count.

Parameters:
- MAX_WAIT, 15, max cycles a memory state may wait with mem_ready low before a timeout trap (1..2^WAIT_W-1)
- WAIT_W, 4, width of wait counter
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- run  in  1  1 = keep issuing instructions; 0 = park in IDLE at next instruction boundary
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  load PC
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- ir_write  out  1  load IR from memory read data
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  register write data from MDR
- reg_write  out  1  register file write enable
- reg_dst  out  1  1 = rd, 0 = rt
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  3  000 add, 100 slt, 110 sub
- inst_done  out  1  one-cycle pulse on the final cycle of each instruction
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- trap  out  1  sticky trap flag
- trap_cause  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout

Behaviour:
- Outputs are decoded from state, plus noted Mealy terms on mem_ready or zero. Unlisted outputs are 0.
- Reset: state = IDLE, wait_cnt = 0, instr_count = 0, trap = 0, trap_cause = 00. All outputs are 0 in IDLE.
- IDLE: all outputs 0. Moves to FETCH when run = 1.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 000, pc_source = 0.
  - ir_write = pc_write = mem_ready (Mealy).
  - On mem_ready, go to DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 000 (branch target into ALUOut).
  - Next state by opcode:
    - 0x00 with funct 0x20 or 0x2A → EXEC_R
    - 0x23, 0x2B, 0x08 → EXEC_I
    - 0x04 → BRANCH
    - anything else → TRAP with cause 01
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 000 for funct 0x20, 100 for 0x2A. Next: WB_R.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 000. Next: lw → MEM_RD, sw → MEM_WR, addi → WB_I.
- MEM_RD: iord = 1, mem_read = 1. Waits for mem_ready, then WB_MEM.
- MEM_WR: iord = 1, mem_write = 1. Waits for mem_ready; inst_done = mem_ready; instruction retires.
- WB_R: reg_write = 1, reg_dst = 1. Retires.
- WB_I: reg_write = 1, reg_dst = 0. Retires.
- WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Retires.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_source = 1, pc_write = zero (Mealy). Retires regardless of zero.
- Retire:
  - inst_done = 1 for one cycle; instr_count increments (wraps).
  - Next state is FETCH if run = 1, else IDLE.
  - run is sampled only at retire and in IDLE; dropping run mid-instruction never aborts it.
- Wait timer:
  - wait_cnt clears on entering any memory state (FETCH, MEM_RD, MEM_WR).
  - It increments each cycle mem_ready = 0 in that state.
  - If mem_ready = 0 while wait_cnt == MAX_WAIT - 1, go to TRAP with cause 10. No request strobe is asserted after that cycle.
  - mem_ready in the same cycle as the limit wins: normal completion.
- TRAP: all strobes 0, trap = 1, trap_cause held. Stays in TRAP until rst; run is ignored.
- Latency in cycles: add/slt/addi 4, lw 5, sw 4, beq 3, with zero-wait memory. Each memory wait cycle adds 1.
- rst asserted in any state, including mid-memory wait: next cycle is IDLE with all outputs 0. Outstanding memory requests are abandoned (memory side must tolerate a dropped request).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, TRAP)
  - opcode/funct constants
  - alu_op codes (ADD = 000, SLT = 100, SUB = 110)
  - alu_src_b codes
  - trap_cause codes
- One sub-module, mem_wait_timer:
  - Inputs: clear, count enable.
  - Outputs: expired flag.
  - Parameters: MAX_WAIT, WAIT_W.

Test Plan:
- rst for 2 cycles, run = 1, add (op 0x00, funct 0x20), mem_ready tied 1 → states IDLE, FETCH, DECODE, EXEC_R, WB_R. reg_dst = reg_write = 1 in WB_R, inst_done pulse, instr_count = 1.
- lw (op 0x23) with mem_ready low 3 cycles in MEM_RD → mem_read and iord held 4 cycles, then WB_MEM with mem_to_reg = 1. Total 8 cycles, instr_count + 1.
- beq (op 0x04) twice: zero = 1 → pc_write = 1, pc_source = 1 in BRANCH; zero = 0 → pc_write = 0. Both retire in 3 cycles.
- Opcode 0x3F, then op 0x00 with funct 0x22 (after reset) → TRAP, trap_cause = 01, all strobes 0 for 20 cycles, instr_count unchanged. rst returns state to IDLE.
- MEM_WR with mem_ready never asserted, MAX_WAIT = 15 → mem_write high exactly 15 cycles, then trap_cause = 10. Repeat with mem_ready on the 15th cycle → normal retire, no trap.
- run dropped during EXEC_I of addi → instruction completes (WB_I, inst_done), FSM parks in IDLE. run = 1 → FETCH next cycle.
